// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Cycles from the accepting start edge to the edge that raises done.
    function automatic int unsigned mul_latency(input int unsigned w);
        return w + 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/cond_negate.sv
// Combinational conditional two's-complement negation.
module cond_negate #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x_i,
    input  logic         neg_i,
    output logic [W-1:0] y_c_o
);

    assign y_c_o = neg_i ? (~x_i + W'(1)) : x_i;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one WIDTH-bit add per cycle, fixed WIDTH+1 latency,
// sign handled by negating operands to magnitudes and negating the final product.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;

    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic [PW-1:0]    res_c;
    logic [WIDTH:0]   sum_c;

    cond_negate #(.W(WIDTH)) u_neg_a (
        .x_i   (a),
        .neg_i (signed_mode & a[WIDTH-1]),
        .y_c_o (mag_a_c)
    );

    cond_negate #(.W(WIDTH)) u_neg_b (
        .x_i   (b),
        .neg_i (signed_mode & b[WIDTH-1]),
        .y_c_o (mag_b_c)
    );

    cond_negate #(.W(PW)) u_neg_p (
        .x_i   ({acc_q, mplr_q}),
        .neg_i (sign_q),
        .y_c_o (res_c)
    );

    // Single WIDTH-bit adder; the carry lands in sum_c[WIDTH] and is shifted back in.
    assign sum_c = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        prod_d  = prod_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;

        case (state_q)
            ST_RUN: begin
                acc_d  = sum_c[WIDTH:1];
                mplr_d = {sum_c[0], mplr_q[WIDTH-1:1]};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                prod_d  = res_c;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                // Unused encoding 2'd3 behaves as IDLE.
                state_d = ST_IDLE;
                if (start) begin
                    acc_d   = '0;
                    mplr_d  = mag_b_c;
                    mcand_d = mag_a_c;
                    sign_d  = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    cnt_d   = CW'(WIDTH);
                    state_d = ST_RUN;
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Parametrised sequential shift-add multiplier with a start/busy/done handshake and a runtime signed/unsigned mode. It computes one WIDTH×WIDTH product per operation in fixed latency using a single WIDTH-bit adder, and holds the result until the next operation. It serves as the arithmetic engine for datapath blocks that can afford multi-cycle latency in exchange for area.

## Interface
Parameters:
- WIDTH, default 5: operand width in bits, ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin; sampled only in IDLE.
- a  input  WIDTH  multiplicand; captured on accepted start.
- b  input  WIDTH  multiplier; captured on accepted start.
- signed_mode  input  1  1 = operands and product are two's complement; 0 = unsigned; captured on accepted start.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  single-cycle pulse; product valid.
- product  output  2*WIDTH  result; holds its value until the next accepted start.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1, latch the operand magnitudes and the result sign, clear the accumulator, load the bit counter with WIDTH, and go to RUN. Otherwise stay in IDLE.
- Operand magnitudes: in unsigned mode, a and b are used as-is. In signed mode, each negative operand is replaced by its two's-complement negation, taken as a WIDTH-bit unsigned value.
  - -2^(WIDTH-1) therefore becomes 2^(WIDTH-1), which is correct unsigned.
- Result sign: a[MSB]^b[MSB] in signed mode; 0 in unsigned mode.
- RUN, one iteration per cycle for WIDTH cycles:
  - If the multiplier LSB is 1, add the multiplicand to the upper WIDTH bits of the accumulator, keeping the carry.
  - Shift the {carry, accumulator} right by 1, with the multiplier shifting into the low half.
  - Decrement the counter. When it reaches 0, go to DONE.
- DONE: product ← accumulator, negated modulo 2^(2*WIDTH) if the result sign is 1. Pulse done and return to IDLE.
- Width rule: all products are exact in 2*WIDTH bits, for both modes.
- start while busy=1, including the DONE cycle, is ignored. It is not queued.
- Changes to a, b or signed_mode after acceptance have no effect on the operation in flight.

## Timing
- Reset values: FSM=IDLE, busy=0, done=0, product=0, internal accumulator and counter=0.
- Reset mid-operation aborts immediately to the reset values. No done pulse is issued for the aborted operation.
- start sampled high at edge N (in IDLE):
  - busy=1 from after edge N.
  - RUN occupies the cycles after edges N..N+WIDTH-1.
  - DONE follows edge N+WIDTH, with done=1 and product valid after edge N+WIDTH+1.
  - busy=0 after edge N+WIDTH+1.
- Fixed latency: done asserts WIDTH+1 cycles after the start edge, independent of operand values. There is no early termination on zero.
- Back-to-back operation: start may be held high. The next start is accepted at the edge where done is shown, giving a throughput of one product per WIDTH+2 cycles.
- product changes only at the edge that raises done, and at reset.

## Structure
- Shared package (mul_pkg):
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2, with 2'd3 decoded to IDLE.
  - MUL_LATENCY(w) = w+1 constant/function.
  - Counter width $clog2(WIDTH+1).
- One sub-module: cond_negate #(W), a combinational conditional two's-complement negation.
  - Instantiated twice at WIDTH for operand magnitudes.
  - Instantiated once at 2*WIDTH for the result.
- The top level holds the FSM, counter, accumulator/shift register and adder.

## Test plan
- Unsigned max, WIDTH=5: a=31, b=31, signed_mode=0 → done exactly 6 cycles after the start edge, product=961 (10'h3C1), busy high for 6 cycles.
- Signed mixed, WIDTH=5: a=-3 (5'h1D), b=7, signed_mode=1 → product=-21 (10'h3EB). Swapping a and b gives the same result.
- Signed corner, WIDTH=5: a=b=-16 (5'h10), signed_mode=1 → product=256 (10'h100). With a=-16, b=15 → product=-240 (10'h310).
- Zero and busy interference: a=0, b=25 → product=0 with full latency. Pulse start again with a=3, b=3 at RUN cycle 2 → ignored; product stays 0, and only one done pulse occurs.
- Reset mid-operation: start a=12, b=9, then assert rst in RUN cycle 3 → busy=0, done=0, product=0 immediately. A fresh start a=2, b=3 then yields product=6 with nominal latency.
- Back-to-back and parameter sweep: hold start high with new operands each accept → one done every WIDTH+2 cycles. Run randomized operands in both modes at WIDTH=5, 8 and 16 against a reference model.
